// File: rtl/alarm_ctrl.sv
// Alarm controller for the digital clock: holds an editable BCD alarm time and
// runs the ring / snooze / dismiss sequence against the running BCD time.
module alarm_ctrl #(
  parameter logic [7:0] DEFAULT_HRS    = 8'h07,
  parameter logic [7:0] DEFAULT_MIN    = 8'h00,
  parameter int         RING_SECONDS   = 60,
  parameter int         SNOOZE_SECONDS = 300,
  parameter int         CNT_W          = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick_1s,
  input  logic [7:0] Hrs,
  input  logic [7:0] Min,
  input  logic [7:0] Sec,
  input  logic       Alarm_En,
  input  logic       Btn_Mode,
  input  logic       Btn_Inc,
  input  logic       Btn_Snooze,
  output logic [7:0] Alarm_Hrs,
  output logic [7:0] Alarm_Min,
  output logic       Set_Hrs,
  output logic       Set_Min,
  output logic       Ringing,
  output logic       Snoozed,
  output logic       Buzzer
);

  typedef enum logic [2:0] {IDLE, SET_HR, SET_MIN, RINGING, SNOOZE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         alarm_hrs_q, alarm_hrs_d;
  logic [7:0]         alarm_min_q, alarm_min_d;
  logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic               buzzer_q, buzzer_d;
  logic               match, match_q, trigger;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)            return 8'h00;
    else if (v[3:0] == 4'h9)   return {v[7:4] + 4'h1, 4'h0};
    else                       return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // A held match (Sec stays 00 for a whole second) fires only on its first cycle.
  assign match   = Alarm_En && (Hrs == alarm_hrs_q) && (Min == alarm_min_q) && (Sec == 8'h00);
  assign trigger = match && !match_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      alarm_hrs_q  <= DEFAULT_HRS;
      alarm_min_q  <= DEFAULT_MIN;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      buzzer_q     <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_hrs_q  <= alarm_hrs_d;
      alarm_min_q  <= alarm_min_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      buzzer_q     <= buzzer_d;
      match_q      <= match;
    end
  end

  // NOTE: every next-state signal gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    alarm_hrs_d  = alarm_hrs_q;
    alarm_min_d  = alarm_min_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    buzzer_d     = buzzer_q;
    unique case (state_q)
      IDLE: begin
        if (Btn_Mode) begin
          state_d = SET_HR;
        end else if (trigger) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          buzzer_d   = 1'b0;
        end
      end
      SET_HR: begin
        if (Btn_Mode)      state_d     = SET_MIN;
        else if (Btn_Inc)  alarm_hrs_d = bcd_inc(alarm_hrs_q, 8'h23);
      end
      SET_MIN: begin
        if (Btn_Mode)      state_d     = IDLE;
        else if (Btn_Inc)  alarm_min_d = bcd_inc(alarm_min_q, 8'h59);
      end
      RINGING: begin
        if (!Alarm_En || Btn_Mode) begin
          state_d = IDLE;
        end else if (Btn_Snooze) begin
          state_d      = SNOOZE;
          snooze_cnt_d = '0;
        end else if (Tick_1s) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d = IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            buzzer_d   = !buzzer_q;
          end
        end
      end
      SNOOZE: begin
        if (!Alarm_En || Btn_Mode) begin
          state_d = IDLE;
        end else if (Tick_1s) begin
          if (snooze_cnt_q == SNOOZE_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            snooze_cnt_d = snooze_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Every ring starts silent, and the buzzer never sounds outside RINGING.
    if (state_d != RINGING || state_q != RINGING) buzzer_d = 1'b0;
  end

  always_comb begin
    Set_Hrs   = (state_q == SET_HR);
    Set_Min   = (state_q == SET_MIN);
    Ringing   = (state_q == RINGING);
    Snoozed   = (state_q == SNOOZE);
    Buzzer    = buzzer_q;
    Alarm_Hrs = alarm_hrs_q;
    Alarm_Min = alarm_min_q;
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with shortened ring/snooze lengths (4 s / 3 s).
module tb_alarm_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Tick_1s, Alarm_En, Btn_Mode, Btn_Inc, Btn_Snooze;
  logic [7:0] Hrs, Min, Sec;
  logic [7:0] Alarm_Hrs, Alarm_Min;
  logic       Set_Hrs, Set_Min, Ringing, Snoozed, Buzzer;
  logic [4:0] flags;

  int passed = 0;
  int total  = 0;

  alarm_ctrl #(
    .DEFAULT_HRS(8'h07), .DEFAULT_MIN(8'h00),
    .RING_SECONDS(4), .SNOOZE_SECONDS(3), .CNT_W(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Tick_1s(Tick_1s),
    .Hrs(Hrs), .Min(Min), .Sec(Sec), .Alarm_En(Alarm_En),
    .Btn_Mode(Btn_Mode), .Btn_Inc(Btn_Inc), .Btn_Snooze(Btn_Snooze),
    .Alarm_Hrs(Alarm_Hrs), .Alarm_Min(Alarm_Min),
    .Set_Hrs(Set_Hrs), .Set_Min(Set_Min), .Ringing(Ringing),
    .Snoozed(Snoozed), .Buzzer(Buzzer)
  );

  always #5 Clk = ~Clk;

  // {Set_Hrs, Set_Min, Ringing, Snoozed, Buzzer}
  assign flags = {Set_Hrs, Set_Min, Ringing, Snoozed, Buzzer};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_mode();
    Btn_Mode = 1'b1; step(); Btn_Mode = 1'b0;
  endtask

  task automatic pulse_inc();
    Btn_Inc = 1'b1; step(); Btn_Inc = 1'b0;
  endtask

  task automatic pulse_snooze();
    Btn_Snooze = 1'b1; step(); Btn_Snooze = 1'b0;
  endtask

  task automatic tick();
    Tick_1s = 1'b1; step(); Tick_1s = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; step(); Reset = 1'b0;
  endtask

  // Leave second 00 then enter it again to produce a fresh trigger at 07:00:00.
  task automatic fire_alarm();
    Hrs = 8'h07; Min = 8'h00; Sec = 8'h01; step();
    Sec = 8'h00; step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (Alarm_Hrs !== 8'h07) $display("FAIL reset_hrs got=%h exp=07", Alarm_Hrs);
    else passed++;
    total++;
    if (Alarm_Min !== 8'h00) $display("FAIL reset_min got=%h exp=00", Alarm_Min);
    else passed++;
    total++;
    if (flags !== 5'b00000) $display("FAIL reset_flags got=%b exp=00000", flags);
    else passed++;
  endtask

  task automatic test_edit();
    pulse_mode();
    total++;
    if (flags !== 5'b10000) $display("FAIL edit_enter_hr got=%b exp=10000", flags);
    else passed++;
    for (int i = 0; i < 16; i++) pulse_inc();
    total++;
    if (Alarm_Hrs !== 8'h23) $display("FAIL edit_hrs_23 got=%h exp=23", Alarm_Hrs);
    else passed++;
    pulse_inc();
    total++;
    if (Alarm_Hrs !== 8'h00) $display("FAIL edit_hrs_wrap got=%h exp=00", Alarm_Hrs);
    else passed++;
    Btn_Mode = 1'b1; Btn_Inc = 1'b1; step(); Btn_Mode = 1'b0; Btn_Inc = 1'b0;
    total++;
    if (flags !== 5'b01000 || Alarm_Hrs !== 8'h00)
      $display("FAIL edit_mode_inc flags=%b hrs=%h exp=01000/00", flags, Alarm_Hrs);
    else passed++;
    for (int i = 0; i < 10; i++) pulse_inc();
    total++;
    if (Alarm_Min !== 8'h10) $display("FAIL edit_min_10 got=%h exp=10", Alarm_Min);
    else passed++;
    for (int i = 0; i < 51; i++) pulse_inc();
    total++;
    if (Alarm_Min !== 8'h01 || Alarm_Hrs !== 8'h00)
      $display("FAIL edit_min_wrap min=%h hrs=%h exp=01/00", Alarm_Min, Alarm_Hrs);
    else passed++;
    pulse_mode();
    total++;
    if (flags !== 5'b00000) $display("FAIL edit_exit got=%b exp=00000", flags);
    else passed++;
    pulse_inc();
    total++;
    if (Alarm_Min !== 8'h01 || Alarm_Hrs !== 8'h00)
      $display("FAIL edit_inc_idle min=%h hrs=%h exp=01/00", Alarm_Min, Alarm_Hrs);
    else passed++;
  endtask

  task automatic test_ring_timeout();
    do_reset();
    Alarm_En = 1'b1;
    Hrs = 8'h06; Min = 8'h59; Sec = 8'h59; step(); step();
    Hrs = 8'h07; Min = 8'h00; Sec = 8'h00; Tick_1s = 1'b1; step(); Tick_1s = 1'b0;
    total++;
    if (flags !== 5'b00100) $display("FAIL ring_start got=%b exp=00100", flags);
    else passed++;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (flags !== 5'b00100) $display("FAIL ring_hold got=%b exp=00100", flags);
    else passed++;
    tick();
    total++;
    if (Buzzer !== 1'b1) $display("FAIL buzz_tick1 got=%b exp=1", Buzzer);
    else passed++;
    tick();
    total++;
    if (Buzzer !== 1'b0) $display("FAIL buzz_tick2 got=%b exp=0", Buzzer);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b00101) $display("FAIL ring_tick3 got=%b exp=00101", flags);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b00000) $display("FAIL ring_timeout got=%b exp=00000", flags);
    else passed++;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (flags !== 5'b00000) $display("FAIL no_retrigger got=%b exp=00000", flags);
    else passed++;
  endtask

  task automatic test_snooze();
    fire_alarm();
    total++;
    if (flags !== 5'b00100) $display("FAIL snz_ring got=%b exp=00100", flags);
    else passed++;
    tick();
    pulse_snooze();
    total++;
    if (flags !== 5'b00010) $display("FAIL snz_enter got=%b exp=00010", flags);
    else passed++;
    tick();
    pulse_snooze();
    tick();
    total++;
    if (flags !== 5'b00010) $display("FAIL snz_tick2 got=%b exp=00010", flags);
    else passed++;
    tick();
    total++;
    if (flags !== 5'b00100) $display("FAIL snz_reRing got=%b exp=00100", flags);
    else passed++;
    pulse_mode();
    total++;
    if (flags !== 5'b00000) $display("FAIL snz_dismiss got=%b exp=00000", flags);
    else passed++;
  endtask

  task automatic test_reset_mid_ring();
    fire_alarm();
    tick();
    total++;
    if (flags !== 5'b00101) $display("FAIL rst_ring_pre got=%b exp=00101", flags);
    else passed++;
    Sec = 8'h01;
    do_reset();
    total++;
    if (flags !== 5'b00000 || Alarm_Hrs !== 8'h07 || Alarm_Min !== 8'h00)
      $display("FAIL rst_ring flags=%b hrs=%h min=%h exp=00000/07/00", flags, Alarm_Hrs, Alarm_Min);
    else passed++;
  endtask

  task automatic test_enable();
    fire_alarm();
    Alarm_En = 1'b0; Sec = 8'h01; step();
    total++;
    if (flags !== 5'b00000) $display("FAIL en_drop_ring got=%b exp=00000", flags);
    else passed++;
    Alarm_En = 1'b1; step();
    fire_alarm();
    pulse_snooze();
    total++;
    if (flags !== 5'b00010) $display("FAIL en_snz_pre got=%b exp=00010", flags);
    else passed++;
    Alarm_En = 1'b0; Sec = 8'h01; step();
    total++;
    if (flags !== 5'b00000) $display("FAIL en_drop_snz got=%b exp=00000", flags);
    else passed++;
    fire_alarm(); step();
    total++;
    if (flags !== 5'b00000) $display("FAIL en_off_match got=%b exp=00000", flags);
    else passed++;
    Alarm_En = 1'b1; Sec = 8'h01; step();
    Sec = 8'h00; Btn_Mode = 1'b1; step(); Btn_Mode = 1'b0;
    total++;
    if (flags !== 5'b10000) $display("FAIL mode_at_trigger got=%b exp=10000", flags);
    else passed++;
    step();
    total++;
    if (flags !== 5'b10000) $display("FAIL trig_in_set got=%b exp=10000", flags);
    else passed++;
    pulse_mode(); pulse_mode(); step();
    total++;
    if (flags !== 5'b00000) $display("FAIL back_idle got=%b exp=00000", flags);
    else passed++;
  endtask

  initial begin
    Reset = 1'b1; Tick_1s = 1'b0; Alarm_En = 1'b0;
    Btn_Mode = 1'b0; Btn_Inc = 1'b0; Btn_Snooze = 1'b0;
    Hrs = 8'h12; Min = 8'h30; Sec = 8'h15;
    step();
    test_reset();
    test_edit();
    test_ring_timeout();
    test_snooze();
    test_reset_mid_ring();
    test_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
